cpu_sequencer: RTL
==================

Name: cpu_sequencer

Overview:
Run-control sequencer for the 8-bit CPU. It owns the 4-bit `cycle` counter that feeds the microcode state decoder, and it watches the decoded `state` coming back. It gates datapath activity through `cpu_en` and implements run, stop, single-step and halt, plus an instruction retire counter. It sits between the front-panel/testbench controls and the CPU core.

Parameters:
CYCLE_MAX, 6, last legal cycle index; if this index is reached with no end-of-instruction state, the sequencer raises a fault and forces cycle to 0.
STATE_NEXT_CODE, 4'd9, encoding of the end-of-instruction state; the integrator sets it to the shared state encoding.
STATE_HALT_CODE, 4'd11, encoding of the halt state; the integrator sets it to the shared state encoding.
CNT_W, 16, width of the retired-instruction counter.
ADDR_W, 4, PC/address width (used only with the optional feature).

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
run  in  1  level; 1 = free-run
step_req  in  1  request to execute one instruction; sampled only in IDLE
restart  in  1  synchronous pulse; leaves HALTED and clears the counters
state  in  4  decoded microcode state from the CPU control decoder
cycle  out  4  current micro-cycle index to the decoder
cpu_en  out  1  datapath/register clock enable
running  out  1  high in RUN
halted  out  1  high in HALTED
step_done  out  1  one-clock pulse at the end of a single step
fault  out  1  sticky; set on a cycle overrun
instr_count  out  CNT_W  count of retired instructions, wrapping

Behaviour:
- One clock: clk. Reset is asynchronous and active-low on reset_n.
- Reset values: FSM=IDLE, cycle=0, instr_count=0, fault=0, step_done=0. `cpu_en`, `running` and `halted` are all 0.
- FSM states are IDLE, RUN, STEP and HALTED. `cpu_en` is combinational and equals (FSM==RUN || FSM==STEP). `running` equals (FSM==RUN). `halted` equals (FSM==HALTED).
- IDLE:
  - run=1 -> RUN.
  - Else step_req=1 -> STEP.
  - run and step_req high together -> RUN wins.
  - cycle holds.
- RUN and STEP share the same per-clock update, evaluated with cpu_en=1 and with priority HALT > NEXT > overrun > increment:
  - state==STATE_HALT_CODE -> HALTED; cycle holds; instr_count unchanged.
  - state==STATE_NEXT_CODE -> cycle<=0 and instr_count<=instr_count+1 (wraps at 2^CNT_W).
  - cycle==CYCLE_MAX (and neither case above) -> cycle<=0, fault<=1, instr_count unchanged.
  - Otherwise -> cycle<=cycle+1.
- Stop at instruction boundary:
  - In RUN, if run==0 on a clock where state==STATE_NEXT_CODE, go to IDLE.
  - Otherwise stay in RUN until that boundary. A mid-instruction stop is never allowed.
- STEP:
  - On STATE_NEXT_CODE -> IDLE, with step_done=1 on the following clock for exactly one clock.
  - On STATE_HALT_CODE -> HALTED, and step_done also pulses once.
  - A step_req held high in IDLE after a step completes starts another step. Benches pulse it for one clock.
- HALTED:
  - cpu_en=0; cycle frozen. run and step_req are ignored.
  - restart=1 -> IDLE, cycle<=0, instr_count<=0, fault<=0.
- restart in IDLE: also clears cycle, instr_count and fault. restart in RUN or STEP is ignored.
- reset_n asserted mid-instruction: all state returns to reset values immediately (async). No instruction completion is implied.
- Latency: a run/step_req sampled at edge N gives cpu_en=1 during the cycle after edge N, and cycle=0 is presented to the decoder at that time.

Optional Feature:
Macro CPU_SEQUENCER_BREAKPOINT_EN.

With the macro defined:
- Extra ports:
  - bp_valid  in  1
  - bp_addr  in  ADDR_W
  - pc  in  ADDR_W
  - bp_hit  out  1 (sticky until the next run/step start)
- In RUN, at cycle==0, if bp_valid and pc==bp_addr:
  - Go to IDLE without advancing cycle.
  - Set bp_hit=1. instr_count is unchanged.
- The first instruction after any IDLE->RUN/STEP transition is exempt from the compare, so resuming does not re-trigger.
- STEP never checks breakpoints.

Without the macro:
- These ports and the logic are absent.
- Behaviour is identical to the above, minus the breakpoint.

Test Plan:
1. Reset then run=1, with the decoder model returning STATE_NEXT_CODE at cycle 4 -> cycle sequence 0,1,2,3,4,0…; instr_count=3 after 15 enabled clocks; running=1.
2. run=1, then deassert run at cycle 2 -> cycle continues 3,4,0; the FSM enters IDLE on the NEXT clock; cpu_en=0 afterwards; cycle stays 0.
3. IDLE, step_req pulse -> one instruction executes (5 clocks); step_done pulses once; instr_count increments by exactly 1; returns to IDLE.
4. Decoder returns STATE_HALT_CODE at cycle 2 -> halted=1; cycle stays 2; run and step ignored for 10 clocks; a restart pulse then gives IDLE with cycle=0, instr_count=0.
5. Decoder never returns NEXT, with CYCLE_MAX=6 -> cycle 0..6 then 0; fault=1 and stays 1 until restart; instr_count unchanged.
6. reset_n pulled low at cycle 3 while in RUN -> all outputs return to reset values asynchronously, without waiting for a clock edge.

Source files
------------

// File: rtl/cpu_sequencer.sv
// Run-control sequencer: owns the micro-cycle counter, gates cpu_en, retires instructions.
// Optional breakpoint unit enabled by defining CPU_SEQUENCER_BREAKPOINT_EN.
module cpu_sequencer #(
  parameter logic [3:0]  CYCLE_MAX       = 4'd6,
  parameter logic [3:0]  STATE_NEXT_CODE = 4'd9,
  parameter logic [3:0]  STATE_HALT_CODE = 4'd11,
  parameter int unsigned CNT_W           = 16,
  parameter int unsigned ADDR_W          = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             run,
  input  logic             step_req,
  input  logic             restart,
  input  logic [3:0]       state,
`ifdef CPU_SEQUENCER_BREAKPOINT_EN
  input  logic             bp_valid,
  input  logic [ADDR_W-1:0] bp_addr,
  input  logic [ADDR_W-1:0] pc,
  output logic             bp_hit,
`endif
  output logic [3:0]       cycle,
  output logic             cpu_en,
  output logic             running,
  output logic             halted,
  output logic             step_done,
  output logic             fault,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_STEP,
    S_HALT
  } fsm_e;

  fsm_e             fsm_q, fsm_d;
  logic [3:0]       cyc_q, cyc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             flt_q, flt_d;
  logic             sd_q, sd_d;
  logic             bp_stop;
  logic             start;

  assign start = (fsm_q == S_IDLE) && (run || step_req);

`ifdef CPU_SEQUENCER_BREAKPOINT_EN
  logic bp_hit_q, bp_hit_d;
  logic exempt_q, exempt_d;

  assign bp_stop = (fsm_q == S_RUN) && (cyc_q == 4'd0) && bp_valid
                   && (pc == bp_addr) && !exempt_q;

  // The first instruction after a start is exempt so resuming never re-hits.
  always_comb begin
    bp_hit_d = bp_hit_q;
    exempt_d = exempt_q;
    if (start) begin
      bp_hit_d = 1'b0;
      exempt_d = 1'b1;
    end else if (bp_stop) begin
      bp_hit_d = 1'b1;
    end else if ((fsm_q == S_RUN || fsm_q == S_STEP)
                 && (state != STATE_HALT_CODE)
                 && (state == STATE_NEXT_CODE || cyc_q == CYCLE_MAX)) begin
      exempt_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bp_hit_q <= 1'b0;
      exempt_q <= 1'b0;
    end else begin
      bp_hit_q <= bp_hit_d;
      exempt_q <= exempt_d;
    end
  end

  assign bp_hit = bp_hit_q;
`else
  assign bp_stop = 1'b0;
`endif

  always_comb begin
    fsm_d = fsm_q;
    cyc_d = cyc_q;
    cnt_d = cnt_q;
    flt_d = flt_q;
    sd_d  = 1'b0;
    unique case (fsm_q)
      S_IDLE: begin
        if (restart) begin
          cyc_d = 4'd0;
          cnt_d = '0;
          flt_d = 1'b0;
        end
        if (run) begin
          fsm_d = S_RUN;
        end else if (step_req) begin
          fsm_d = S_STEP;
        end
      end
      S_RUN, S_STEP: begin
        if (bp_stop) begin
          fsm_d = S_IDLE;
        end else if (state == STATE_HALT_CODE) begin
          fsm_d = S_HALT;
          sd_d  = (fsm_q == S_STEP);
        end else if (state == STATE_NEXT_CODE) begin
          cyc_d = 4'd0;
          cnt_d = cnt_q + CNT_W'(1);
          if (fsm_q == S_STEP) begin
            fsm_d = S_IDLE;
            sd_d  = 1'b1;
          end else if (!run) begin
            fsm_d = S_IDLE;
          end
        end else if (cyc_q == CYCLE_MAX) begin
          cyc_d = 4'd0;
          flt_d = 1'b1;
        end else begin
          cyc_d = cyc_q + 4'd1;
        end
      end
      S_HALT: begin
        if (restart) begin
          fsm_d = S_IDLE;
          cyc_d = 4'd0;
          cnt_d = '0;
          flt_d = 1'b0;
        end
      end
      default: fsm_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fsm_q <= S_IDLE;
      cyc_q <= 4'd0;
      cnt_q <= '0;
      flt_q <= 1'b0;
      sd_q  <= 1'b0;
    end else begin
      fsm_q <= fsm_d;
      cyc_q <= cyc_d;
      cnt_q <= cnt_d;
      flt_q <= flt_d;
      sd_q  <= sd_d;
    end
  end

  assign cycle       = cyc_q;
  assign cpu_en      = (fsm_q == S_RUN) || (fsm_q == S_STEP);
  assign running     = (fsm_q == S_RUN);
  assign halted      = (fsm_q == S_HALT);
  assign step_done   = sd_q;
  assign fault       = flt_q;
  assign instr_count = cnt_q;

endmodule
